// File: rtl/fetch_pc_if.sv
// rtl/fetch_pc_if.sv - instruction-memory request/ready handshake between fetch_pc and imem
interface fetch_pc_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter and fetch FSM with redirect and misaligned-target trap
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  add4Out,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  fetch_pc_if.master   imem,
  output logic [31:0]  pcOut,
  output logic [31:0]  instr_out,
  output logic         fetch_valid,
  output logic [31:0]  instr_pc,
  output logic         misalign_err
);

  typedef enum logic {SETTLE, REQ} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        req_q, req_d;
  logic        fv_q, fv_d;
  logic        mis_q, mis_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        redir_apply;
  logic [31:0] redir_tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SETTLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      ipc_q        <= '0;
      req_q        <= 1'b0;
      fv_q         <= 1'b0;
      mis_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      ipc_q        <= ipc_d;
      req_q        <= req_d;
      fv_q         <= fv_d;
      mis_q        <= mis_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    ipc_d        = ipc_q;
    req_d        = req_q;
    fv_d         = 1'b0;
    mis_d        = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    redir_apply  = 1'b0;
    redir_tgt    = redirect_pc;

    case (state_q)
      SETTLE: begin
        if (redirect_valid) begin
          redir_apply = 1'b1;
        end else if (!stall) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (imem.imem_ready) begin
          // A same-cycle redirect beats the pending one; either way the fetched word is dropped
          if (redirect_valid) begin
            redir_apply = 1'b1;
          end else if (pend_valid_q) begin
            redir_apply = 1'b1;
            redir_tgt   = pend_pc_q;
          end else begin
            instr_d = imem.imem_rdata;
            ipc_d   = pc_q;
            fv_d    = 1'b1;
            pc_d    = add4Out;
          end
          pend_valid_d = 1'b0;
          req_d        = 1'b0;
          state_d      = SETTLE;
        end else if (redirect_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end
      end
      default: state_d = SETTLE;
    endcase

    if (redir_apply) begin
      if (redir_tgt[1:0] == 2'b00) begin
        pc_d = redir_tgt;
      end else begin
        pc_d  = TRAP_PC;
        mis_d = 1'b1;
      end
    end
  end

  assign pcOut          = pc_q;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_out      = instr_q;
  assign instr_pc       = ipc_q;
  assign fetch_valid    = fv_q;
  assign misalign_err   = mis_q;

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - scoreboard bench for fetch_pc with an add4 model and an imem responder
module tb_fetch_pc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] add4Out;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] pcOut, instr_out, instr_pc;
  logic        fetch_valid, misalign_err;

  logic        auto_rdy = 1'b0;
  logic        man_rdy = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  fetch_pc_if mem();

  fetch_pc dut (
    .clk            (clk),
    .reset          (reset),
    .add4Out        (add4Out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem           (mem.master),
    .pcOut          (pcOut),
    .instr_out      (instr_out),
    .fetch_valid    (fetch_valid),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) add4Out <= 32'h4;
    else       add4Out <= pcOut + 32'h4;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign mem.imem_rdata = mem_word(mem.imem_addr);
  assign mem.imem_ready = auto_rdy ? mem.imem_req : man_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && fetch_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_fetch", instr_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq("instr_pc", instr_pc, e);
        check_eq("instr_out", instr_out, mem_word(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fv(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!fetch_valid && n < 20);
    if (!fetch_valid) check_eq({tag, "_timeout"}, 32'(n), 32'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    auto_rdy = 1'b0; man_rdy = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int prev;
    // reset state
    do_reset();
    check_eq("rst_pc", pcOut, 32'h0);
    check_eq("rst_req", {31'b0, mem.imem_req}, 32'h0);
    check_eq("rst_fv", {31'b0, fetch_valid}, 32'h0);
    check_eq("rst_instr", instr_out, 32'h0);
    check_eq("rst_ipc", instr_pc, 32'h0);
    check_eq("rst_mis", {31'b0, misalign_err}, 32'h0);

    // free-run: one fetch every 2 cycles
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    auto_rdy = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_fv("free_run");
      if (i > 0) check_eq("fetch_period", 32'(cyc - prev), 32'd2);
      prev = cyc;
    end
    check_eq("pc_after_4", pcOut, 32'h10);
    stall = 1'b1;
    tick();

    // imem_ready held low for 3 cycles at pc 0x8
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    auto_rdy = 1'b1;
    wait_fv("pre_wait"); wait_fv("pre_wait");
    auto_rdy = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq("wait_req", {31'b0, mem.imem_req}, 32'h1);
      check_eq("wait_addr", mem.imem_addr, 32'h8);
      if (k == 3) man_rdy = 1'b1;
      tick();
    end
    check_eq("wait_fv", {31'b0, fetch_valid}, 32'h1);
    man_rdy = 1'b0; stall = 1'b1;
    tick();
    check_eq("wait_fv_once", {31'b0, fetch_valid}, 32'h0);
    tick(); tick();

    // pending redirect arriving one cycle before ready at pc 0xC
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    auto_rdy = 1'b1;
    wait_fv("pre_redir"); wait_fv("pre_redir"); wait_fv("pre_redir");
    auto_rdy = 1'b0;
    tick();
    check_eq("redir_addr", mem.imem_addr, 32'hC);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    check_eq("redir_hold_pc", pcOut, 32'hC);
    check_eq("redir_hold_req", {31'b0, mem.imem_req}, 32'h1);
    redirect_valid = 1'b0; man_rdy = 1'b1;
    tick();
    check_eq("redir_pc", pcOut, 32'h40);
    check_eq("redir_no_fv", {31'b0, fetch_valid}, 32'h0);
    check_eq("redir_req_drop", {31'b0, mem.imem_req}, 32'h0);
    man_rdy = 1'b0;
    exp_q.push_back(32'h40);
    auto_rdy = 1'b1;
    wait_fv("redir_fetch");

    // two redirects during one outstanding request; newest wins
    auto_rdy = 1'b0;
    tick();
    check_eq("dbl_addr", mem.imem_addr, 32'h44);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_pc = 32'h90;
    tick();
    redirect_valid = 1'b0; man_rdy = 1'b1;
    tick();
    check_eq("dbl_pc", pcOut, 32'h90);
    man_rdy = 1'b0;
    tick();
    // same-cycle redirect overrides the pending target
    redirect_valid = 1'b1; redirect_pc = 32'hA0;
    tick();
    redirect_pc = 32'hB0; man_rdy = 1'b1;
    tick();
    check_eq("prio_pc", pcOut, 32'hB0);
    redirect_valid = 1'b0; man_rdy = 1'b0;
    exp_q.push_back(32'hB0);
    auto_rdy = 1'b1;
    wait_fv("prio_fetch");

    // misaligned redirect in SETTLE traps to TRAP_PC
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    check_eq("mis_pulse", {31'b0, misalign_err}, 32'h1);
    check_eq("mis_pc", pcOut, 32'h100);
    redirect_valid = 1'b0;
    exp_q.push_back(32'h100);
    tick();
    check_eq("mis_one_cycle", {31'b0, misalign_err}, 32'h0);
    wait_fv("trap_fetch");

    // top of address space wraps through add4
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_mis", {31'b0, misalign_err}, 32'h0);
    wait_fv("wrap_fetch");
    check_eq("wrap_pc", pcOut, 32'h0);
    stall = 1'b1;
    tick();

    // stall in SETTLE at 0x20, then async reset mid-request
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    auto_rdy = 1'b1;
    for (int i = 0; i < 8; i++) wait_fv("pre_stall");
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("stall_req", {31'b0, mem.imem_req}, 32'h0);
      check_eq("stall_pc", pcOut, 32'h20);
    end
    auto_rdy = 1'b0; stall = 1'b0;
    tick();
    check_eq("req_after_stall", {31'b0, mem.imem_req}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_pc", pcOut, 32'h0);
    check_eq("async_rst_req", {31'b0, mem.imem_req}, 32'h0);
    tick();
    reset = 1'b0;

    check_eq("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
